// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator for a word-wide
// data memory. Loads extract and extend byte/half lanes; sub-word stores
// use read-modify-write because the memory only writes whole words.
// Misaligned accesses and illegal funct3 codes complete immediately with
// resp_err and never touch the memory.

module lsu_mem_master #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_WD,
    output logic              mem_WE,
    input  logic [31:0]       mem_RD
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    // Illegal funct3: stores accept only 000/001/010, loads reject 011/110/111.
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = f3[2] || (f3[1:0] == 2'b11);
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

    // Halves need an even address, words need a multiple of four.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Select the addressed lane of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Overlay the store byte/half onto the word just read back from memory.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [15:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (f3[1:0])
            2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = wd;
                end else begin
                    r[15:0] = wd;
                end
            end
            default: r = word;
        endcase
        return r;
    endfunction

    logic [1:0]        state_r,  state_s;
    logic [1:0]        lane_r,   lane_s;
    logic              we_r,     we_s;
    logic [2:0]        funct3_r, funct3_s;
    logic [15:0]       wdata_r,  wdata_s;
    logic [2:0]        cnt_r,    cnt_s;
    logic              req_ready_s;
    logic              resp_valid_s;
    logic [31:0]       resp_rdata_s;
    logic              resp_err_s;
    logic [ADDR_W-1:0] mem_a_s;
    logic [31:0]       mem_wd_s;
    logic              mem_we_s;
    logic              bad_s;

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_s      = state_r;
        lane_s       = lane_r;
        we_s         = we_r;
        funct3_s     = funct3_r;
        wdata_s      = wdata_r;
        cnt_s        = cnt_r;
        resp_valid_s = 1'b0;
        resp_rdata_s = resp_rdata;
        resp_err_s   = 1'b0;
        mem_a_s      = mem_A;
        mem_wd_s     = mem_WD;
        mem_we_s     = 1'b0;
        bad_s        = is_illegal(req_we, req_funct3) ||
                       is_misaligned(req_funct3, req_addr[1:0]);

        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    lane_s   = req_addr[1:0];
                    we_s     = req_we;
                    funct3_s = req_funct3;
                    wdata_s  = req_wdata[15:0];
                    if (bad_s) begin
                        state_s      = ST_DONE;
                        resp_valid_s = 1'b1;
                        resp_err_s   = 1'b1;
                        resp_rdata_s = 32'd0;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        // Full-word store needs no read-back.
                        state_s  = ST_WRITE;
                        mem_a_s  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wd_s = req_wdata;
                        mem_we_s = 1'b1;
                    end else begin
                        // Loads and sub-word stores both read the word first.
                        state_s = ST_READ;
                        cnt_s   = LAT_INIT;
                        mem_a_s = {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_r == 3'd1) begin
                    cnt_s = 3'd0;
                    if (we_r) begin
                        state_s  = ST_WRITE;
                        mem_wd_s = merge_store(mem_RD, wdata_r, funct3_r, lane_r);
                        mem_we_s = 1'b1;
                    end else begin
                        state_s      = ST_DONE;
                        resp_valid_s = 1'b1;
                        resp_rdata_s = extract_load(mem_RD, funct3_r, lane_r);
                    end
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            ST_WRITE: begin
                state_s      = ST_DONE;
                resp_valid_s = 1'b1;
                resp_rdata_s = 32'd0;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        req_ready_s = (state_s == ST_IDLE);
    end

    // State, request latches and all outputs registered; rst low clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            lane_r     <= 2'd0;
            we_r       <= 1'b0;
            funct3_r   <= 3'd0;
            wdata_r    <= 16'd0;
            cnt_r      <= 3'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_A      <= '0;
            mem_WD     <= 32'd0;
            mem_WE     <= 1'b0;
        end else begin
            state_r    <= state_s;
            lane_r     <= lane_s;
            we_r       <= we_s;
            funct3_r   <= funct3_s;
            wdata_r    <= wdata_s;
            cnt_r      <= cnt_s;
            req_ready  <= req_ready_s;
            resp_valid <= resp_valid_s;
            resp_rdata <= resp_rdata_s;
            resp_err   <= resp_err_s;
            mem_A      <= mem_a_s;
            mem_WD     <= mem_wd_s;
            mem_WE     <= mem_we_s;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master: two instances (RD_LAT=1 and RD_LAT=3) each
// attached to a small word memory; directed and random requests are checked
// against an arithmetic reference model of the load/store rules.

module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        v0, v1;
    logic        rdy0, rdy1, rv0, rv1, err0, err1, we0, we1;
    logic [31:0] rdata0, rdata1, a0, a1, wd0, wd1, rd0, rd1;

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];
    logic [31:0] ref_mem [2][16];
    logic [31:0] a1_d1, a1_d2;

    logic        pre_we;
    int          pre_sel;
    logic [3:0]  pre_idx;
    logic [31:0] pre_d;

    int          s;
    logic        c_rdy, c_rv, c_err, c_we;
    logic [31:0] c_rdata, c_a, c_wd;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata, last_wd, last_wa;
    int          last_lat;

    always #5 clk = ~clk;

    lsu_mem_master #(.RD_LAT(1), .ADDR_W(32)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0),
        .mem_A(a0), .mem_WD(wd0), .mem_WE(we0), .mem_RD(rd0)
    );

    lsu_mem_master #(.RD_LAT(3), .ADDR_W(32)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rdata1), .resp_err(err1),
        .mem_A(a1), .mem_WD(wd1), .mem_WE(we1), .mem_RD(rd1)
    );

    // Memory 0 reads combinationally; memory 1 returns data two edges after mem_A.
    assign rd0 = mem0[a0[5:2]];
    assign rd1 = mem1[a1_d2[5:2]];

    // Address pipeline giving memory 1 its read latency.
    always @(posedge clk) begin
        a1_d1 <= a1;
        a1_d2 <= a1_d1;
    end

    // Word-write memories with a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) begin
            if (pre_sel == 0) mem0[pre_idx] <= pre_d;
            else              mem1[pre_idx] <= pre_d;
        end
        if (we0) mem0[a0[5:2]] <= wd0;
        if (we1) mem1[a1[5:2]] <= wd1;
    end

    // View of whichever instance is under test.
    always_comb begin
        c_rdy   = (s == 0) ? rdy0   : rdy1;
        c_rv    = (s == 0) ? rv0    : rv1;
        c_err   = (s == 0) ? err0   : err1;
        c_we    = (s == 0) ? we0    : we1;
        c_rdata = (s == 0) ? rdata0 : rdata1;
        c_a     = (s == 0) ? a0     : a1;
        c_wd    = (s == 0) ? wd0    : wd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (inst %0d): observed=%h expected=%h", tag, s, obs, exp);
        end
    endtask

    task automatic set_sel(input int k);
        s = k;
        #1;
    endtask

    task automatic preload(input int k, input int idx, input logic [31:0] d);
        pre_sel = k;
        pre_idx = 4'(idx);
        pre_d   = d;
        pre_we  = 1'b1;
        ref_mem[k][idx] = d;
        @(posedge clk);
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input int k, input int idx);
        return (k == 0) ? mem0[idx] : mem1[idx];
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, c_rdy}, 32'd1);
        chk({tag, "_rvalid"}, {31'd0, c_rv}, 32'd0);
        chk({tag, "_rerr"}, {31'd0, c_err}, 32'd0);
        chk({tag, "_rdata"}, c_rdata, 32'd0);
        chk({tag, "_we"}, {31'd0, c_we}, 32'd0);
        chk({tag, "_addr"}, c_a, 32'd0);
        chk({tag, "_wd"}, c_wd, 32'd0);
    endtask

    // One request against the selected instance, checked against the model.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
        int rl, exp_lat, lat, we_cnt, sh, widx;
        logic ill, mis, exp_err, exp_wr, got;
        logic [31:0] word, exp_rd, exp_wd, exp_wa, mask, obs_a, obs_wd;

        rl   = (s == 0) ? 1 : 3;
        widx = int'(addr[5:2]);
        word = ref_mem[s][widx];
        ill  = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis  = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
        exp_err = ill || mis;
        exp_rd  = 32'd0;
        exp_wr  = 1'b0;
        exp_wd  = 32'd0;
        exp_wa  = {addr[31:2], 2'b00};
        if (exp_err) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = rl + 1;
            if (f3[1:0] == 2'd0) begin
                sh = 8 * int'(addr[1:0]);
                exp_rd = (word >> sh) & 32'hFF;
                if (!f3[2] && exp_rd >= 32'd128) exp_rd = exp_rd + 32'hFFFFFF00;
            end else if (f3[1:0] == 2'd1) begin
                sh = 16 * int'(addr[1]);
                exp_rd = (word >> sh) & 32'hFFFF;
                if (!f3[2] && exp_rd >= 32'd32768) exp_rd = exp_rd + 32'hFFFF0000;
            end else begin
                exp_rd = word;
            end
        end else begin
            exp_wr = 1'b1;
            if (f3 == 3'd2) begin
                exp_lat = 2;
                exp_wd  = wd;
            end else begin
                exp_lat = rl + 2;
                if (f3 == 3'd0) begin
                    sh = 8 * int'(addr[1:0]);
                    mask = 32'hFF << sh;
                    exp_wd = (word & ~mask) | ((wd & 32'hFF) << sh);
                end else begin
                    sh = 16 * int'(addr[1]);
                    mask = 32'hFFFF << sh;
                    exp_wd = (word & ~mask) | ((wd & 32'hFFFF) << sh);
                end
            end
        end

        chk("ready_before", {31'd0, c_rdy}, 32'd1);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        if (s == 0) v0 = 1'b1; else v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;
        lat = 1; we_cnt = 0; got = 1'b0; obs_a = 32'd0; obs_wd = 32'd0;
        while (!got && lat <= 20) begin
            if (c_we) begin
                we_cnt++;
                obs_a  = c_a;
                obs_wd = c_wd;
            end
            if (c_rv) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL resp_timeout (inst %0d): observed=no resp_valid expected=resp_valid", s);
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_err", {31'd0, c_err}, {31'd0, exp_err});
        chk("resp_rdata", c_rdata, exp_rd);
        chk("we_cycles", 32'(we_cnt), exp_wr ? 32'd1 : 32'd0);
        if (exp_wr) begin
            chk("wr_addr", obs_a, exp_wa);
            chk("wr_data", obs_wd, exp_wd);
            ref_mem[s][widx] = exp_wd;
        end
        last_rdata = c_rdata;
        last_wd    = obs_wd;
        last_wa    = obs_a;
        last_lat   = lat;
        @(negedge clk);
        chk("resp_pulse", {31'd0, c_rv}, 32'd0);
        chk("ready_after", {31'd0, c_rdy}, 32'd1);
        chk("mem_word", mem_word(s, widx), ref_mem[s][widx]);
    endtask

    // Accept an SB, then pull rst low during READ: nothing must be written.
    task automatic reset_mid(input logic [31:0] addr);
        int widx, we_cnt;
        widx = int'(addr[5:2]);
        req_we = 1'b1; req_funct3 = 3'd0; req_addr = addr; req_wdata = $urandom;
        if (s == 0) v0 = 1'b1; else v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_reset_outputs("mid_rst");
        we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (c_we) we_cnt++;
        end
        chk("mid_rst_we_cycles", 32'(we_cnt), 32'd0);
        chk("mid_rst_mem", mem_word(s, widx), ref_mem[s][widx]);
    endtask

    initial begin
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; pre_we = 1'b0; pre_sel = 0;
        pre_idx = 4'd0; pre_d = 32'd0;
        req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        s = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_sel(0); check_reset_outputs("reset");
        set_sel(1); check_reset_outputs("reset");
        rst = 1'b1;

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) preload(k, i, $urandom);

        // Directed sequence on the RD_LAT=1 instance.
        set_sel(0);
        preload(0, 0, 32'h00000005);
        preload(0, 1, 32'hFFFFFFFB);
        do_req(1'b0, 3'b000, 32'd4, 32'd0); chk("tp_lb4", last_rdata, 32'hFFFFFFFB);
        chk("tp_lb4_lat", 32'(last_lat), 32'd2);
        do_req(1'b0, 3'b100, 32'd4, 32'd0); chk("tp_lbu4", last_rdata, 32'h000000FB);
        do_req(1'b0, 3'b010, 32'd0, 32'd0); chk("tp_lw0", last_rdata, 32'h00000005);
        preload(0, 1, 32'h8CDEFAB7);
        do_req(1'b0, 3'b001, 32'd6, 32'd0); chk("tp_lh6", last_rdata, 32'hFFFF8CDE);
        do_req(1'b0, 3'b101, 32'd4, 32'd0); chk("tp_lhu4", last_rdata, 32'h0000FAB7);
        do_req(1'b0, 3'b000, 32'd5, 32'd0); chk("tp_lb5", last_rdata, 32'hFFFFFFFA);
        do_req(1'b1, 3'b000, 32'd1, 32'h123456AB);
        chk("tp_sb_wd", last_wd, 32'h0000AB05);
        chk("tp_sb_wa", last_wa, 32'd0);
        chk("tp_sb_lat", 32'(last_lat), 32'd3);
        do_req(1'b0, 3'b010, 32'd0, 32'd0); chk("tp_lw_after_sb", last_rdata, 32'h0000AB05);
        do_req(1'b1, 3'b010, 32'd8, 32'hDEADBEEF);
        chk("tp_sw_wd", last_wd, 32'hDEADBEEF);
        chk("tp_sw_wa", last_wa, 32'd8);
        do_req(1'b1, 3'b001, 32'd10, 32'h00001234);
        do_req(1'b0, 3'b010, 32'd8, 32'd0); chk("tp_sh_word2", last_rdata, 32'h1234BEEF);
        do_req(1'b0, 3'b010, 32'd2, 32'd0);
        do_req(1'b1, 3'b001, 32'd3, 32'hFFFFFFFF);
        do_req(1'b0, 3'b011, 32'd0, 32'd0);
        chk("tp_err_lat", 32'(last_lat), 32'd1);
        reset_mid(32'd1);

        // RD_LAT=3 instance: longer read latency and mid-operation reset.
        set_sel(1);
        do_req(1'b0, 3'b010, 32'd12, 32'd0);
        chk("lat3_lw", 32'(last_lat), 32'd4);
        do_req(1'b1, 3'b001, 32'd14, 32'h0000C0DE);
        chk("lat3_sh", 32'(last_lat), 32'd5);
        reset_mid(32'd6);

        // Random traffic on both instances.
        for (int k = 0; k < 2; k++) begin
            set_sel(k);
            for (int n = 0; n < 40; n++) begin
                do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       32'($urandom_range(0, 63)), $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
